// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial WIDTH-bit unsigned subtractor (a - b). A single 1-bit
// full-subtractor cell is reused LSB first, one bit per clock, behind a
// start/busy/done handshake. diff/bout update only on the completion edge.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;      // minuend, shifted right each RUN cycle
  logic [WIDTH-1:0] sb_r;      // subtrahend, shifted right each RUN cycle
  logic [WIDTH-2:0] res_r;     // upper partial-result bits; the new bit enters at the MSB
  logic             borrow_r;  // borrow carried between bit positions
  logic [CW-1:0]    cnt_r;     // index of the bit being processed

  logic [1:0]       cell_s;    // {borrow_out, difference} from the shared cell
  logic [WIDTH-1:0] result_s;  // partial result including this cycle's bit
  logic             last_s;    // this cycle processes the MSB

  // One-bit full subtractor built from two half subtractors plus the
  // borrow OR. Returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
    logic hd;
    logic hb1;
    logic hb2;
    hd  = x ^ y;
    hb1 = ~x & y;
    hb2 = ~hd & br;
    return {hb1 | hb2, hd ^ br};
  endfunction

  // Shared cell evaluation and next partial-result assembly.
  always_comb begin
    cell_s   = full_sub(sa_r[0], sb_r[0], borrow_r);
    result_s = {cell_s[0], res_r};
    last_s   = (cnt_r == CNT_LAST);
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      sa_r     <= {WIDTH{1'b0}};
      sb_r     <= {WIDTH{1'b0}};
      res_r    <= {(WIDTH-1){1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= {WIDTH{1'b0}};
      bout     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_r     <= a;
            sb_r     <= b;
            res_r    <= {(WIDTH-1){1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            busy     <= 1'b1;
            state_r  <= S_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
          res_r    <= result_s[WIDTH-1:1];
          borrow_r <= cell_s[1];
          if (last_s) begin
            cnt_r   <= {CW{1'b0}};
            diff    <= result_s;
            bout    <= cell_s[1];
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= S_RUN;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          cnt_r   <= {CW{1'b0}};
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
